// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clk_div_ctrl divider slice.
// FSM state encoding, default reset divisor and an index-width helper.
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    ACK       = 2'd2
  } state_e;

  localparam int DEF_RST_DIV = 1;

  // Index width that stays legal for a single requester
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Requester-side handshake bundle for clk_div_ctrl: divisor requests in,
// grant/ack/busy back out to the control logic.
interface clk_div_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int W     = 16
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] div_in;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   grant;
  logic               busy;

  modport master (output req, div_in, input ack, grant, busy);
  modport slave  (input req, div_in, output ack, grant, busy);
endinterface

// File: rtl/clk_div_ctrl_core.sv
// clk_div_core: phase counter, divided clock and active divisor register.
// A one-cycle load strobe swaps in a new divisor and restarts the count.
module clk_div_core
  import clk_div_ctrl_pkg::*;
#(
  parameter int W       = 16,
  parameter int RST_DIV = DEF_RST_DIV
) (
  input  logic         clkin,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_div,
  output logic [W-1:0] cur_div,
  output logic         tick,
  output logic         clkout
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic         clkout_q, clkout_d;
  logic         at_end;

  // Zero divisor is excluded before the compare, so cur_div_q-1 never wraps
  assign at_end = (cur_div_q != '0) && (cnt_q == cur_div_q - W'(1));

  always_comb begin
    cnt_d     = cnt_q;
    clkout_d  = clkout_q;
    cur_div_d = cur_div_q;
    if (at_end) begin
      cnt_d    = '0;
      clkout_d = ~clkout_q;
    end else if (cur_div_q != '0) begin
      cnt_d = cnt_q + W'(1);
    end
    if (load) begin
      cur_div_d = load_div;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clkin) begin
    if (!reset) begin
      cnt_q     <= '0;
      clkout_q  <= 1'b0;
      cur_div_q <= W'(RST_DIV);
    end else begin
      cnt_q     <= cnt_d;
      clkout_q  <= clkout_d;
      cur_div_q <= cur_div_d;
    end
  end

  assign tick    = reset & at_end;
  assign cur_div = cur_div_q;
  assign clkout  = clkout_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: round-robin arbitration of divisor requests onto one glitch-free divider.
// Optional CLK_DIV_CTRL_LOCK_EN adds a lock input that holds off new grants.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = 16,
  parameter int RST_DIV = DEF_RST_DIV
) (
  input  logic         clkin,
  input  logic         reset,
`ifdef CLK_DIV_CTRL_LOCK_EN
  input  logic         lock,
`endif
  clk_div_ctrl_if.slave bus,
  output logic [W-1:0] cur_div,
  output logic         tick,
  output logic         clkout
);

  localparam int PW = idx_w(N_REQ);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [W-1:0]     pend_div_q, pend_div_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_idx;
  logic             win_vld;
  logic             can_grant;
  logic             edge_ok;
  logic             load;
  logic [W-1:0]     div_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_div
    assign div_arr[gi] = bus.div_in[gi*W +: W];
  end

  // Scan downward so the candidate closest after the pointer wins last
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(ptr_q) + k) % N_REQ]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

`ifdef CLK_DIV_CTRL_LOCK_EN
  assign can_grant = win_vld & ~lock;
`else
  assign can_grant = win_vld;
`endif

  // A stopped divider has no edge to wait for, so the swap is immediate
  assign edge_ok = tick | (cur_div == '0);

  always_ff @(posedge clkin) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      pend_div_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      pend_div_q <= pend_div_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (can_grant) state_d = WAIT_EDGE;
      WAIT_EDGE: if (edge_ok)   state_d = ACK;
      ACK:                      state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    ack_d      = '0;
    pend_div_d = pend_div_q;
    ptr_d      = ptr_q;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_grant) begin
          grant_d    = N_REQ'(1) << win_idx;
          pend_div_d = div_arr[win_idx];
          ptr_d      = PW'((int'(win_idx) + 1) % N_REQ);
        end
      end
      WAIT_EDGE: load = edge_ok;
      ACK: begin
        ack_d   = grant_q;
        grant_d = '0;
      end
      default: ;
    endcase
  end

  assign bus.grant = grant_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = (state_q != IDLE);

  clk_div_core #(
    .W       (W),
    .RST_DIV (RST_DIV)
  ) u_core (
    .clkin    (clkin),
    .reset    (reset),
    .load     (load),
    .load_div (pend_div_q),
    .cur_div  (cur_div),
    .tick     (tick),
    .clkout   (clkout)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl (4 requesters, 16-bit divisors, RST_DIV=1).
// Lock scenario is compiled in only with CLK_DIV_CTRL_LOCK_EN.
module tb_clk_div_ctrl;

  logic        clkin = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cur_div;
  logic        tick;
  logic        clkout;
`ifdef CLK_DIV_CTRL_LOCK_EN
  logic        lock = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_ctrl_if #(.N_REQ(4), .W(16)) bus ();

  clk_div_ctrl #(.N_REQ(4), .W(16), .RST_DIV(1)) dut (
    .clkin   (clkin),
    .reset   (reset),
`ifdef CLK_DIV_CTRL_LOCK_EN
    .lock    (lock),
`endif
    .bus     (bus),
    .cur_div (cur_div),
    .tick    (tick),
    .clkout  (clkout)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input int d);
    bus.div_in[i*16 +: 16] = d[15:0];
    bus.req[i] = 1'b1;
  endtask

  // Counts falling edges until an ack is seen (bounded)
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clkin);
      n++;
    end while (bus.ack == '0 && n < 300);
    $display("txn: ack=%b cur_div=%0d after %0d cycles", bus.ack, cur_div, n);
  endtask

  // Measures the length of the next full clkout phase, tick to tick
  task automatic phase_len(input string tag, input int exp);
    int n;
    int bad;
    logic lvl;
    n = 0;
    while (tick !== 1'b1 && n < 300) begin
      @(negedge clkin);
      n++;
    end
    @(negedge clkin);
    n = 1;
    lvl = clkout;
    bad = 0;
    while (tick !== 1'b1 && n < 300) begin
      @(negedge clkin);
      n++;
      if (clkout !== lvl) bad++;
    end
    check({tag, "_len"}, n, exp);
    check({tag, "_steady"}, bad, 0);
  endtask

  initial begin
    int n;
    int bad;
    logic lvl;
    int divs[4]     = '{3, 4, 5, 6};
    int exp_wait[4] = '{3, 2, 3, 4};

    bus.req    = '0;
    bus.div_in = '0;

    // Reset state, then divide-by-1 toggling
    repeat (3) @(negedge clkin);
    check("rst_clkout", clkout, 0);
    check("rst_cur_div", cur_div, 1);
    check("rst_ack", bus.ack, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_tick", tick, 0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clkin);
      check("t1_clkout", clkout, (k % 2 == 0) ? 1 : 0);
      check("t1_tick", tick, 1);
    end

    // Single request; req dropped right after grant must not cancel
    set_req(2, 5);
    @(negedge clkin);
    check("t2_grant", bus.grant, 4);
    check("t2_busy", bus.busy, 1);
    check("t2_cur_div_old", cur_div, 1);
    bus.req[2] = 1'b0;
    @(negedge clkin);
    check("t2_cur_div_new", cur_div, 5);
    check("t2_ack_early", bus.ack, 0);
    @(negedge clkin);
    check("t2_ack", bus.ack, 4);
    check("t2_grant_clr", bus.grant, 0);
    check("t2_busy_clr", bus.busy, 0);
    $display("txn: ack=%b cur_div=%0d", bus.ack, cur_div);
    @(negedge clkin);
    check("t2_ack_pulse", bus.ack, 0);
    phase_len("t2_ph_a", 5);
    phase_len("t2_ph_b", 5);

    // Four simultaneous requests from a fresh round-robin pointer
    reset = 1'b0;
    repeat (2) @(negedge clkin);
    reset = 1'b1;
    @(negedge clkin);
    for (int i = 0; i < 4; i++) set_req(i, divs[i]);
    for (int i = 0; i < 4; i++) begin
      wait_ack(n);
      check("t3_wait", n, exp_wait[i]);
      check("t3_ack", bus.ack, 1 << i);
      check("t3_cur_div", cur_div, divs[i]);
      bus.req[i] = 1'b0;
      @(negedge clkin);
      check("t3_ack_pulse", bus.ack, 0);
      check("t3_next_grant", bus.grant, (i < 3) ? (1 << (i + 1)) : 0);
    end
    phase_len("t3_ph_a", 6);
    phase_len("t3_ph_b", 6);

    // Stop the divider, then restart it while stopped
    set_req(1, 0);
    wait_ack(n);
    check("t4_ack_stop", bus.ack, 2);
    check("t4_cur_div_stop", cur_div, 0);
    bus.req[1] = 1'b0;
    lvl = clkout;
    bad = 0;
    repeat (10) begin
      @(negedge clkin);
      if (clkout !== lvl || tick !== 1'b0) bad++;
    end
    check("t4_frozen", bad, 0);
    set_req(3, 7);
    wait_ack(n);
    check("t4_restart_wait", n, 3);
    check("t4_ack_restart", bus.ack, 8);
    check("t4_cur_div_restart", cur_div, 7);
    bus.req[3] = 1'b0;
    phase_len("t4_ph_a", 7);
    phase_len("t4_ph_b", 7);

    // Reset while waiting for the edge abandons the transaction
    set_req(0, 9);
    @(negedge clkin);
    check("t5_busy", bus.busy, 1);
    reset = 1'b0;
    @(negedge clkin);
    check("t5_ack", bus.ack, 0);
    check("t5_grant", bus.grant, 0);
    check("t5_busy_clr", bus.busy, 0);
    check("t5_clkout", clkout, 0);
    check("t5_cur_div", cur_div, 1);
    check("t5_tick", tick, 0);
    bus.req = '0;
    @(negedge clkin);
    check("t5_no_ack", bus.ack, 0);
    reset = 1'b1;
    @(negedge clkin);

    // Requesting the divisor already in effect still completes
    set_req(1, 1);
    wait_ack(n);
    check("t7_same_wait", n, 3);
    check("t7_same_ack", bus.ack, 2);
    check("t7_same_cur_div", cur_div, 1);
    bus.req[1] = 1'b0;
    @(negedge clkin);

`ifdef CLK_DIV_CTRL_LOCK_EN
    // Lock holds off granting until released
    lock = 1'b1;
    set_req(0, 4);
    bad = 0;
    repeat (20) begin
      @(negedge clkin);
      if (bus.grant != '0) bad++;
    end
    check("t6_lock_hold", bad, 0);
    lock = 1'b0;
    @(negedge clkin);
    check("t6_lock_grant", bus.grant, 1);
    wait_ack(n);
    check("t6_lock_ack", bus.ack, 1);
    bus.req[0] = 1'b0;
    @(negedge clkin);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
